// File: rtl/ntt_sched_pkg.sv
// Shared types for the NTT/PWM butterfly sequencer.
package ntt_sched_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} schedState_t;

    localparam logic MODE_NTT = 1'b0;
    localparam logic MODE_PWM = 1'b1;
endpackage

// File: rtl/ntt_wb_delay.sv
// Write-back delay line: carries {en, addrA, addrB} from issue to the BFU output.
module ntt_wb_delay #(
    parameter int LOGN   = 8,
    parameter int WB_LAT = 6
) (
    input  logic            iSYS_CLK,
    input  logic            iSYS_RST,
    input  logic            iEn,
    input  logic [LOGN-1:0] iAddrA,
    input  logic [LOGN-1:0] iAddrB,
    output logic            oEn,
    output logic [LOGN-1:0] oAddrA,
    output logic [LOGN-1:0] oAddrB
);
    logic [WB_LAT-1:0] enPipe;
    logic [LOGN-1:0]   addrAPipe [WB_LAT];
    logic [LOGN-1:0]   addrBPipe [WB_LAT];

    // Clearing the whole line on reset is what drops in-flight write-backs.
    always_ff @(posedge iSYS_CLK or posedge iSYS_RST) begin
        if (iSYS_RST) begin
            enPipe <= '0;
            for (int i = 0; i < WB_LAT; i++) begin
                addrAPipe[i] <= '0;
                addrBPipe[i] <= '0;
            end
        end else begin
            enPipe[0]    <= iEn;
            addrAPipe[0] <= iAddrA;
            addrBPipe[0] <= iAddrB;
            for (int i = 1; i < WB_LAT; i++) begin
                enPipe[i]    <= enPipe[i-1];
                addrAPipe[i] <= addrAPipe[i-1];
                addrBPipe[i] <= addrBPipe[i-1];
            end
        end
    end

    assign oEn    = enPipe[WB_LAT-1];
    assign oAddrA = addrAPipe[WB_LAT-1];
    assign oAddrB = addrBPipe[WB_LAT-1];
endmodule

// File: rtl/ntt_bfu_sched.sv
// Butterfly sequencer: issues one Cooley-Tukey butterfly (or PWM pair) per cycle
// and drains the BFU pipe between stages.
module ntt_bfu_sched
    import ntt_sched_pkg::*;
#(
    parameter int LOGN   = 8,
    parameter int WB_LAT = 6
) (
    input  logic            iSYS_CLK,
    input  logic            iSYS_RST,
    input  logic            iFSM_START,
    input  logic            iMODE,
    output logic            oBUSY,
    output logic            oDONE,
    output logic            oSEL,
    output logic [LOGN-1:0] oSTAGE,
    output logic            oRD_EN,
    output logic [LOGN-1:0] oRD_ADDR_A,
    output logic [LOGN-1:0] oRD_ADDR_B,
    output logic [LOGN-1:0] oTW_ADDR,
    output logic            oWR_EN,
    output logic [LOGN-1:0] oWR_ADDR_A,
    output logic [LOGN-1:0] oWR_ADDR_B
);
    localparam int HALF = 1 << (LOGN - 1);
    localparam int JW   = LOGN - 1;
    localparam int DW   = $clog2(WB_LAT + 1);

    schedState_t     state;
    logic            modeLat;
    logic [LOGN-1:0] stage;
    logic [JW-1:0]   jCnt;
    logic [DW-1:0]   drainCnt;

    logic            genMode;
    logic [LOGN-1:0] genStage;
    logic [JW-1:0]   genJ;
    logic [LOGN-1:0] jExt, lenV, gV, oV, aV, bV, twV;
    int              shAmt;

    // Addresses are computed for the butterfly that will be visible next cycle.
    always_comb begin
        genMode  = (state == ST_IDLE) ? iMODE : modeLat;
        genStage = (state == ST_DRAIN) ? stage + LOGN'(1) :
                   ((state == ST_IDLE) ? '0 : stage);
        genJ     = (state == ST_ISSUE) ? jCnt + JW'(1) : '0;
        jExt     = {1'b0, genJ};
        shAmt    = LOGN - 1 - int'(genStage);
        lenV     = '0;
        gV       = '0;
        oV       = '0;
        aV       = '0;
        bV       = '0;
        twV      = '0;
        if (genMode == MODE_PWM) begin
            aV  = {genJ, 1'b0};
            bV  = {genJ, 1'b1};
            twV = jExt;
        end else begin
            lenV = LOGN'(1) << shAmt;
            gV   = jExt >> shAmt;
            oV   = jExt & (lenV - LOGN'(1));
            aV   = (gV << (shAmt + 1)) | oV;
            bV   = aV + lenV;
            twV  = (LOGN'(1) << genStage) + gV;
        end
    end

    always_ff @(posedge iSYS_CLK or posedge iSYS_RST) begin
        if (iSYS_RST) begin
            state      <= ST_IDLE;
            modeLat    <= MODE_NTT;
            stage      <= '0;
            jCnt       <= '0;
            drainCnt   <= '0;
            oBUSY      <= 1'b0;
            oDONE      <= 1'b0;
            oSEL       <= 1'b0;
            oSTAGE     <= '0;
            oRD_EN     <= 1'b0;
            oRD_ADDR_A <= '0;
            oRD_ADDR_B <= '0;
            oTW_ADDR   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    oDONE <= 1'b0;
                    if (iFSM_START) begin
                        state      <= ST_ISSUE;
                        modeLat    <= iMODE;
                        stage      <= '0;
                        jCnt       <= '0;
                        oBUSY      <= 1'b1;
                        oSEL       <= iMODE;
                        oSTAGE     <= '0;
                        oRD_EN     <= 1'b1;
                        oRD_ADDR_A <= aV;
                        oRD_ADDR_B <= bV;
                        oTW_ADDR   <= twV;
                    end
                end
                ST_ISSUE: begin
                    if (jCnt == JW'(HALF - 1)) begin
                        state    <= ST_DRAIN;
                        drainCnt <= '0;
                        oRD_EN   <= 1'b0;
                    end else begin
                        jCnt       <= jCnt + JW'(1);
                        oRD_ADDR_A <= aV;
                        oRD_ADDR_B <= bV;
                        oTW_ADDR   <= twV;
                    end
                end
                ST_DRAIN: begin
                    if (drainCnt == DW'(WB_LAT - 1)) begin
                        if (modeLat == MODE_NTT && stage < LOGN'(LOGN - 1)) begin
                            state      <= ST_ISSUE;
                            stage      <= stage + LOGN'(1);
                            jCnt       <= '0;
                            oSTAGE     <= stage + LOGN'(1);
                            oRD_EN     <= 1'b1;
                            oRD_ADDR_A <= aV;
                            oRD_ADDR_B <= bV;
                            oTW_ADDR   <= twV;
                        end else begin
                            state  <= ST_DONE;
                            oDONE  <= 1'b1;
                            oBUSY  <= 1'b0;
                            oSEL   <= 1'b0;
                            oSTAGE <= '0;
                        end
                    end else begin
                        drainCnt <= drainCnt + DW'(1);
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    oDONE <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    ntt_wb_delay #(.LOGN(LOGN), .WB_LAT(WB_LAT)) uWbDelay (
        .iSYS_CLK (iSYS_CLK),
        .iSYS_RST (iSYS_RST),
        .iEn      (oRD_EN),
        .iAddrA   (oRD_ADDR_A),
        .iAddrB   (oRD_ADDR_B),
        .oEn      (oWR_EN),
        .oAddrA   (oWR_ADDR_A),
        .oAddrB   (oWR_ADDR_B)
    );
endmodule

// File: tb/tb_ntt_bfu_sched.sv
// Scoreboard bench for ntt_bfu_sched: LOGN=3 and LOGN=8 instances, expected
// issue/write-back streams generated from the textbook nested-loop NTT walk.
module tb_ntt_bfu_sched;
    localparam int WB = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst3, start3, mode3;
    logic       busy3, done3, sel3, rdEn3, wrEn3;
    logic [2:0] stage3, rdA3, rdB3, tw3, wrA3, wrB3;

    logic       rst8, start8, mode8;
    logic       busy8, done8, sel8, rdEn8, wrEn8;
    logic [7:0] stage8, rdA8, rdB8, tw8, wrA8, wrB8;

    ntt_bfu_sched #(.LOGN(3), .WB_LAT(WB)) dut3 (
        .iSYS_CLK(clk), .iSYS_RST(rst3), .iFSM_START(start3), .iMODE(mode3),
        .oBUSY(busy3), .oDONE(done3), .oSEL(sel3), .oSTAGE(stage3),
        .oRD_EN(rdEn3), .oRD_ADDR_A(rdA3), .oRD_ADDR_B(rdB3), .oTW_ADDR(tw3),
        .oWR_EN(wrEn3), .oWR_ADDR_A(wrA3), .oWR_ADDR_B(wrB3)
    );

    ntt_bfu_sched #(.LOGN(8), .WB_LAT(WB)) dut8 (
        .iSYS_CLK(clk), .iSYS_RST(rst8), .iFSM_START(start8), .iMODE(mode8),
        .oBUSY(busy8), .oDONE(done8), .oSEL(sel8), .oSTAGE(stage8),
        .oRD_EN(rdEn8), .oRD_ADDR_A(rdA8), .oRD_ADDR_B(rdB8), .oTW_ADDR(tw8),
        .oWR_EN(wrEn8), .oWR_ADDR_A(wrA8), .oWR_ADDR_B(wrB8)
    );

    typedef struct {
        int cyc;
        int a;
        int b;
        int tw;
        int st;
        bit sel;
    } ev_t;

    ev_t rdQ[$];
    ev_t wrQ[$];
    bit  busyExp [0:1199];
    bit  doneExp [0:1199];
    int  checks = 0;
    int  errors = 0;
    int  wrCount = 0;

    task automatic clear_model();
        rdQ.delete();
        wrQ.delete();
        for (int i = 0; i < 1200; i++) begin
            busyExp[i] = 1'b0;
            doneExp[i] = 1'b0;
        end
    endtask

    // base = cycle index of the edge that accepts start; first issue is base+1.
    task automatic push_run(input int logN, input bit mode, input int base);
        int n, per, nst, idx, len, doneAt;
        ev_t e;
        n   = 1 << logN;
        per = n / 2 + WB;
        nst = mode ? 1 : logN;
        for (int s = 0; s < nst; s++) begin
            idx = 0;
            len = n >> (s + 1);
            if (mode) begin
                for (int j = 0; j < n / 2; j++) begin
                    e.cyc = base + 1 + j; e.a = 2 * j; e.b = 2 * j + 1;
                    e.tw = j; e.st = 0; e.sel = 1'b1;
                    rdQ.push_back(e);
                    e.cyc = e.cyc + WB;
                    wrQ.push_back(e);
                end
            end else begin
                for (int grp = 0; grp < n; grp += 2 * len) begin
                    for (int o = 0; o < len; o++) begin
                        e.cyc = base + s * per + 1 + idx; e.a = grp + o; e.b = grp + o + len;
                        e.tw = (1 << s) + grp / (2 * len); e.st = s; e.sel = 1'b0;
                        rdQ.push_back(e);
                        e.cyc = e.cyc + WB;
                        wrQ.push_back(e);
                        idx++;
                    end
                end
            end
        end
        doneAt = base + nst * per + 1;
        for (int c = base + 1; c < doneAt; c++) busyExp[c] = 1'b1;
        doneExp[doneAt] = 1'b1;
    endtask

    // Samples one instance on falling edges for nCyc cycles and scores it.
    task automatic watch(input bit big, input int nCyc);
        logic       rdE, wrE, bsy, dn, sl;
        logic [7:0] st, ra, rb, tw, wa, wb;
        ev_t e;
        for (int c = 1; c <= nCyc; c++) begin
            @(negedge clk);
            rdE = big ? rdEn8 : rdEn3;
            wrE = big ? wrEn8 : wrEn3;
            bsy = big ? busy8 : busy3;
            dn  = big ? done8 : done3;
            sl  = big ? sel8  : sel3;
            st  = big ? stage8 : {5'b0, stage3};
            ra  = big ? rdA8 : {5'b0, rdA3};
            rb  = big ? rdB8 : {5'b0, rdB3};
            tw  = big ? tw8  : {5'b0, tw3};
            wa  = big ? wrA8 : {5'b0, wrA3};
            wb  = big ? wrB8 : {5'b0, wrB3};

            checks++;
            if (bsy !== busyExp[c]) begin
                errors++;
                $display("FAIL busy cyc %0d got %b exp %b", c, bsy, busyExp[c]);
            end
            checks++;
            if (dn !== doneExp[c]) begin
                errors++;
                $display("FAIL done cyc %0d got %b exp %b", c, dn, doneExp[c]);
            end
            if (rdE === 1'b1) begin
                checks++;
                if (rdQ.size() == 0) begin
                    errors++;
                    $display("FAIL rd_extra cyc %0d got A=%0d B=%0d exp no read", c, ra, rb);
                end else begin
                    e = rdQ.pop_front();
                    if (c !== e.cyc || ra !== 8'(e.a) || rb !== 8'(e.b) || tw !== 8'(e.tw) ||
                        st !== 8'(e.st) || sl !== e.sel) begin
                        errors++;
                        $display("FAIL rd cyc %0d got A=%0d B=%0d TW=%0d st=%0d sel=%b exp cyc %0d A=%0d B=%0d TW=%0d st=%0d sel=%b",
                                 c, ra, rb, tw, st, sl, e.cyc, e.a, e.b, e.tw, e.st, e.sel);
                    end
                end
            end
            if (wrE === 1'b1) begin
                wrCount++;
                checks++;
                if (wrQ.size() == 0) begin
                    errors++;
                    $display("FAIL wr_extra cyc %0d got A=%0d B=%0d exp no write", c, wa, wb);
                end else begin
                    e = wrQ.pop_front();
                    if (c !== e.cyc || wa !== 8'(e.a) || wb !== 8'(e.b)) begin
                        errors++;
                        $display("FAIL wr cyc %0d got A=%0d B=%0d exp cyc %0d A=%0d B=%0d",
                                 c, wa, wb, e.cyc, e.a, e.b);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rst3 = 1'b1; rst8 = 1'b1;
        start3 = 1'b0; mode3 = 1'b0; start8 = 1'b0; mode8 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy3, done3, sel3, stage3, rdEn3, rdA3, rdB3, tw3, wrEn3, wrA3, wrB3} !== '0) begin
            errors++;
            $display("FAIL reset3 got %b exp all zero",
                     {busy3, done3, sel3, stage3, rdEn3, rdA3, rdB3, tw3, wrEn3, wrA3, wrB3});
        end
        checks++;
        if ({busy8, done8, sel8, stage8, rdEn8, rdA8, rdB8, tw8, wrEn8, wrA8, wrB8} !== '0) begin
            errors++;
            $display("FAIL reset8 got %b exp all zero",
                     {busy8, done8, sel8, stage8, rdEn8, rdA8, rdB8, tw8, wrEn8, wrA8, wrB8});
        end
        rst3 = 1'b0; rst8 = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_drained(input string tag);
        checks++;
        if (rdQ.size() != 0 || wrQ.size() != 0) begin
            errors++;
            $display("FAIL %s_leftover got rd=%0d wr=%0d pending exp 0 0", tag, rdQ.size(), wrQ.size());
        end
    endtask

    task automatic test_ntt3();
        clear_model();
        push_run(3, 1'b0, 0);
        start3 = 1'b1; mode3 = 1'b0;
        fork
            begin @(negedge clk); start3 = 1'b0; end
            watch(1'b0, 34);
        join
        check_drained("ntt3");
    endtask

    task automatic test_pwm3();
        clear_model();
        push_run(3, 1'b1, 0);
        start3 = 1'b1; mode3 = 1'b1;
        fork
            begin @(negedge clk); start3 = 1'b0; mode3 = 1'b0; end
            watch(1'b0, 14);
        join
        check_drained("pwm3");
    endtask

    task automatic test_back_to_back();
        clear_model();
        push_run(3, 1'b0, 0);
        push_run(3, 1'b1, 32);
        start3 = 1'b1; mode3 = 1'b0;
        fork
            begin
                repeat (15) @(negedge clk);
                mode3 = 1'b1;
                repeat (21) @(negedge clk);
                mode3 = 1'b0;
                repeat (7) @(negedge clk);
                start3 = 1'b0;
            end
            watch(1'b0, 50);
        join
        check_drained("b2b");
    endtask

    task automatic test_reset_mid_run();
        clear_model();
        push_run(3, 1'b0, 0);
        start3 = 1'b1; mode3 = 1'b0;
        fork
            begin @(negedge clk); start3 = 1'b0; end
            watch(1'b0, 7);
        join
        @(negedge clk);
        rst3 = 1'b1;
        #1;
        checks++;
        if ({busy3, done3, sel3, stage3, rdEn3, rdA3, rdB3, tw3, wrEn3, wrA3, wrB3} !== '0) begin
            errors++;
            $display("FAIL midrst got %b exp all zero",
                     {busy3, done3, sel3, stage3, rdEn3, rdA3, rdB3, tw3, wrEn3, wrA3, wrB3});
        end
        @(negedge clk);
        @(negedge clk);
        rst3 = 1'b0;
        clear_model();
        watch(1'b0, 20);
        clear_model();
        push_run(3, 1'b0, 0);
        start3 = 1'b1;
        fork
            begin @(negedge clk); start3 = 1'b0; end
            watch(1'b0, 33);
        join
        check_drained("rst_rerun");
    endtask

    task automatic test_ntt8();
        clear_model();
        push_run(8, 1'b0, 0);
        wrCount = 0;
        start8 = 1'b1; mode8 = 1'b0;
        fork
            begin @(negedge clk); start8 = 1'b0; end
            watch(1'b1, 1076);
        join
        check_drained("ntt8");
        checks++;
        if (wrCount != 1024) begin
            errors++;
            $display("FAIL wr_count8 got %0d exp 1024", wrCount);
        end
    endtask

    initial begin
        test_reset();
        test_ntt3();
        test_pwm3();
        test_back_to_back();
        test_reset_mid_run();
        test_ntt8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ntt_bfu_sched.md
Name: ntt_bfu_sched

Overview:
- Sequencer for the 5-stage pipelined butterfly/PWM unit (q = 134250497, 28-bit data).
- Walks all Cooley-Tukey NTT stages, or one pointwise-multiply (PWM) pass, over an N-point coefficient RAM.
- Issues one butterfly per cycle: read addresses, twiddle-ROM index and BFU sel.
- Delays write-back addresses by the read + pipeline latency, and drains the pipe at every stage boundary so no stage reads stale data.

Parameters:
- LOGN, 8, log2 of transform size N (N = 256); minimum 2.
- WB_LAT, 6, cycles from oRD_EN to the matching oWR_EN (1 RAM read + 5 BFU stages); minimum 1.

Ports:
- iSYS_CLK  in  1  system clock, rising edge.
- iSYS_RST  in  1  asynchronous, active-high reset.
- iFSM_START  in  1  start pulse; sampled only in IDLE.
- iMODE  in  1  0 = NTT (all LOGN stages), 1 = PWM (single pass).
- oBUSY  out  1  high from the cycle after start is accepted until oDONE.
- oDONE  out  1  one-cycle completion pulse.
- oSEL  out  1  BFU mode select; equals latched mode while busy.
- oSTAGE  out  LOGN  current stage index.
- oRD_EN  out  1  read/issue strobe.
- oRD_ADDR_A  out  LOGN  butterfly upper-operand address.
- oRD_ADDR_B  out  LOGN  butterfly lower-operand address.
- oTW_ADDR  out  LOGN  twiddle-ROM index, aligned with oRD_EN.
- oWR_EN  out  1  write-back strobe.
- oWR_ADDR_A  out  LOGN  write address for BFU oA.
- oWR_ADDR_B  out  LOGN  write address for BFU oB.

Behaviour:
- Reset: all outputs 0; state IDLE; counters, latched mode and the whole write-back delay line cleared.
  - Reset mid-operation discards all in-flight write-backs; no oWR_EN follows reset release.
- All outputs are registered.
- States:
  - IDLE: on iFSM_START = 1, latch iMODE, stage = 0, j = 0, go to ISSUE.
  - ISSUE: oRD_EN = 1 each cycle. j counts 0..N/2-1. At j = N/2-1, go to DRAIN with drain counter = 0.
  - DRAIN: oRD_EN = 0 for exactly WB_LAT cycles. Then:
    - NTT and stage < LOGN-1: stage++, j = 0, back to ISSUE.
    - Otherwise: go to DONE.
  - DONE: oDONE = 1 and oBUSY = 0 for one cycle, then IDLE.
- iFSM_START outside IDLE is ignored.
- iMODE changes after acceptance have no effect.
- NTT address generation, stage s:
  - len = N >> (s+1); g = j >> (LOGN-1-s); o = j & (len-1).
  - A = 2·g·len + o; B = A + len; TW = (1 << s) + g.
- PWM address generation: A = 2j, B = 2j+1, TW = j, stage = 0.
- Write-back: oWR_EN / oWR_ADDR_A / oWR_ADDR_B equal oRD_EN / oRD_ADDR_A / oRD_ADDR_B delayed exactly WB_LAT cycles.
  - The last write of a stage lands in the final DRAIN cycle.
  - The next stage's first read is in the following cycle.
- Timing, start sampled at edge 0:
  - First ISSUE at cycle 1.
  - NTT total = LOGN·(N/2 + WB_LAT) cycles, oDONE at cycle LOGN·(N/2 + WB_LAT) + 1.
  - PWM oDONE at cycle N/2 + WB_LAT + 1.
- oBUSY = 1 during ISSUE and DRAIN only.
- Address arithmetic is modulo 2^LOGN; values never exceed N-1 by construction.

Decomposition:
- Package ntt_sched_pkg:
  - State encoding (IDLE, ISSUE, DRAIN, DONE).
  - Mode constants MODE_NTT = 0, MODE_PWM = 1.
- Sub-module ntt_wb_delay: parameterised WB_LAT-deep shift register carrying {en, addrA, addrB}, asynchronously cleared by iSYS_RST.
- Address generation stays inline as combinational logic feeding the output registers.

Test Plan:
1. LOGN = 3, WB_LAT = 6, NTT start at cycle 0:
   - Stage 0, cycles 1-4: (A, B, TW) = (0,4,1), (1,5,1), (2,6,1), (3,7,1).
   - Stage 1, cycles 11-14: (0,2,2), (1,3,2), (4,6,3), (5,7,3).
   - Stage 2, cycles 21-24: (0,1,4), (2,3,5), (4,5,6), (6,7,7).
   - oDONE at cycle 31; oBUSY high cycles 1-30.
2. Same config: oWR_EN high exactly at cycles 7-10, 17-20 and 27-30, with write addresses matching the reads 6 cycles earlier. oRD_EN is never high during DRAIN.
3. PWM, LOGN = 3:
   - Cycles 1-4: (0,1,0), (1,… no: (0,1,0), (2,3,1), (4,5,2), (6,7,3); oSEL = 1.
   - oWR_EN at cycles 7-10; oDONE at cycle 11; oSTAGE = 0 throughout.
4. iFSM_START held high through a whole NTT run, with iMODE toggled mid-run:
   - Exactly one run occurs, in the latched mode.
   - A second run starts on the edge after the DONE cycle.
5. Assert iSYS_RST at cycle 8 of an NTT run (writes in flight):
   - All outputs go to 0 immediately.
   - After release there is no oWR_EN and no oDONE until a new start; a new start gives the scenario 1 sequence.
6. LOGN = 8, WB_LAT = 6, NTT:
   - oDONE at cycle 8·(128+6)+1 = 1073.
   - Last-stage issues: (254, 255, 255) at cycle 1066.
   - Total oWR_EN count = 1024.
